// File: rtl/regfile_pkg.sv
// Shared types and sizes for the register-file write-back path.
package regfile_pkg;

    localparam int DATA_W   = 64;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_queue.sv
// Generic DEPTH-entry in-order FIFO of write-back entries. The entry array and
// per-slot valid bits are exposed so the top level can search in-flight writes.
module wb_queue
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  wb_entry_t                    push_entry_i,
    input  logic                         pop_i,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output wb_entry_t                    head_o,
    output wb_entry_t [DEPTH-1:0]        entries_o,
    output logic [DEPTH-1:0]             valid_o,
    output logic [$clog2(DEPTH)-1:0]     rd_ptr_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    wb_entry_t [DEPTH-1:0] entries_q;
    logic [DEPTH-1:0]      valid_q,  valid_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q,  count_d;
    logic                  push_ok_s;
    logic                  pop_ok_s;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == CNT_W'(0));
    assign push_ok_s = push_i & ~full_o;
    assign pop_ok_s  = pop_i & ~empty_o;

    assign count_o   = count_q;
    assign head_o    = entries_q[rd_ptr_q];
    assign entries_o = entries_q;
    assign valid_o   = valid_q;
    assign rd_ptr_o  = rd_ptr_q;

    // Next-state for pointers, occupancy and valid bits; pointers wrap modulo DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        valid_d  = valid_q;
        if (pop_ok_s) begin
            rd_ptr_d          = rd_ptr_q + PTR_W'(1);
            valid_d[rd_ptr_q] = 1'b0;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (push_ok_s) begin
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
            valid_d[wr_ptr_q] = 1'b1;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= PTR_W'(0);
            rd_ptr_q <= PTR_W'(0);
            count_q  <= CNT_W'(0);
            valid_q  <= DEPTH'(0);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
    end

    // Entry storage, written at the tail on an accepted push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '{addr: ADDR_W'(0), data: DATA_W'(0)};
            end
        end else if (push_ok_s) begin
            entries_q[wr_ptr_q] <= push_entry_i;
        end
    end

endmodule

// File: rtl/regfile_wb_queue.sv
// Write-back queue for the 32 x 64-bit register file: r0 filter, one drain per
// cycle and an optional in-flight lookup enabled by REGFILE_WB_FWD_EN.
module regfile_wb_queue
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [ADDR_W-1:0]            in_addr,
    input  logic [DATA_W-1:0]            in_data,
    input  logic                         wb_stall,
    output logic                         out_we,
    output logic [ADDR_W-1:0]            out_wa,
    output logic [DATA_W-1:0]            out_wd,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    input  logic [ADDR_W-1:0]            fwd_ra,
    output logic                         fwd_hit,
    output logic [DATA_W-1:0]            fwd_data
);

    localparam int PTR_W = $clog2(DEPTH);

    wb_entry_t             push_entry_s;
    wb_entry_t             head_s;
    wb_entry_t [DEPTH-1:0] entries_s;
    logic [DEPTH-1:0]      valid_s;
    logic [PTR_W-1:0]      rd_ptr_s;
    logic                  full_s;
    logic                  empty_s;
    logic                  accept_s;
    logic                  push_s;
    logic                  pop_s;

    // Ready depends on state only, so a full queue refuses even while it drains.
    assign in_ready     = rst_n & ~full_s;
    assign accept_s     = in_valid & in_ready;
    assign push_s       = accept_s & (in_addr != ADDR_W'(0));
    assign push_entry_s = '{addr: in_addr, data: in_data};
    assign pop_s        = ~empty_s & ~wb_stall;

    wb_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (push_s),
        .push_entry_i (push_entry_s),
        .pop_i        (pop_s),
        .full_o       (full_s),
        .empty_o      (empty_s),
        .count_o      (count),
        .head_o       (head_s),
        .entries_o    (entries_s),
        .valid_o      (valid_s),
        .rd_ptr_o     (rd_ptr_s)
    );

    // Regfile port follows the head; idle address/data are forced to zero.
    always_comb begin
        out_we = pop_s;
        if (empty_s) begin
            out_wa = ADDR_W'(0);
            out_wd = DATA_W'(0);
        end else begin
            out_wa = head_s.addr;
            out_wd = head_s.data;
        end
    end

`ifdef REGFILE_WB_FWD_EN
    logic [PTR_W-1:0] fwd_idx_s;

    // Walk oldest to youngest so the last match is the youngest entry.
    always_comb begin
        fwd_hit   = 1'b0;
        fwd_data  = DATA_W'(0);
        fwd_idx_s = rd_ptr_s;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx_s = rd_ptr_s + PTR_W'(i);
            if (valid_s[fwd_idx_s] && (entries_s[fwd_idx_s].addr == fwd_ra) &&
                (fwd_ra != ADDR_W'(0))) begin
                fwd_hit  = 1'b1;
                fwd_data = entries_s[fwd_idx_s].data;
            end else begin
                fwd_hit  = fwd_hit;
                fwd_data = fwd_data;
            end
        end
    end
`else
    logic unused_fwd_s;

    assign unused_fwd_s = ^{rd_ptr_s, valid_s, entries_s, fwd_ra};
    assign fwd_hit      = 1'b0;
    assign fwd_data     = DATA_W'(0);
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed self-checking bench for regfile_wb_queue (both REGFILE_WB_FWD_EN builds).
module tb_regfile_wb_queue;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_addr;
    logic [63:0] in_data;
    logic        wb_stall;
    logic        out_we;
    logic [4:0]  out_wa;
    logic [63:0] out_wd;
    logic [2:0]  count;
    logic [4:0]  fwd_ra;
    logic        fwd_hit;
    logic [63:0] fwd_data;

    int n_cmp;
    int n_err;

`ifdef REGFILE_WB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    regfile_wb_queue #(.DEPTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_addr  (in_addr),
        .in_data  (in_data),
        .wb_stall (wb_stall),
        .out_we   (out_we),
        .out_wa   (out_wa),
        .out_wd   (out_wd),
        .count    (count),
        .fwd_ra   (fwd_ra),
        .fwd_hit  (fwd_hit),
        .fwd_data (fwd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] a, input logic [63:0] d);
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_addr = 5'd0; in_data = 64'd0;
        wb_stall = 1'b0; fwd_ra = 5'd0;
        #12;
        n_cmp++; if (out_we !== 1'b0) begin n_err++; $display("FAIL rst_we got %0b want 0", out_we); end
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL rst_count got %0d want 0", count); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready got %0b want 0", in_ready); end
        n_cmp++; if ({out_wa, out_wd} !== 69'd0) begin n_err++; $display("FAIL rst_wa_wd got %0h/%0h want 0/0", out_wa, out_wd); end
        n_cmp++; if ({fwd_hit, fwd_data} !== 65'd0) begin n_err++; $display("FAIL rst_fwd got %0b/%0h want 0/0", fwd_hit, fwd_data); end
        rst_n = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rel_ready got %0b want 1", in_ready); end
    endtask

    task automatic test_single_write();
        push(5'd5, 64'hDEAD);
        n_cmp++; if (out_we !== 1'b1) begin n_err++; $display("FAIL t1_we got %0b want 1", out_we); end
        n_cmp++; if (out_wa !== 5'd5) begin n_err++; $display("FAIL t1_wa got %0d want 5", out_wa); end
        n_cmp++; if (out_wd !== 64'hDEAD) begin n_err++; $display("FAIL t1_wd got %0h want dead", out_wd); end
        n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL t1_count got %0d want 1", count); end
        step();
        n_cmp++; if (out_we !== 1'b0) begin n_err++; $display("FAIL t1_we_once got %0b want 0", out_we); end
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL t1_count_after got %0d want 0", count); end
    endtask

    task automatic test_r0_drop();
        in_valid = 1'b1; in_addr = 5'd0; in_data = 64'hFFFF;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL t2_ready got %0b want 1", in_ready); end
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL t2_count got %0d want 0", count); end
            n_cmp++; if (out_we !== 1'b0) begin n_err++; $display("FAIL t2_we got %0b want 0", out_we); end
            n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL t2_ready_after got %0b want 1", in_ready); end
            step();
        end
    endtask

    task automatic test_full_and_order();
        logic [4:0]  exp_wa [5];
        logic [63:0] exp_wd [5];
        logic [2:0]  exp_cnt [5];
        exp_wa = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd6};
        exp_wd = '{64'h11, 64'h22, 64'h33, 64'h44, 64'h66};
        exp_cnt = '{3'd4, 3'd3, 3'd3, 3'd2, 3'd1};
        wb_stall = 1'b1;
        push(5'd1, 64'h11); push(5'd2, 64'h22); push(5'd3, 64'h33); push(5'd4, 64'h44);
        in_valid = 1'b1; in_addr = 5'd6; in_data = 64'h66;
        #1;
        n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL t3_count_full got %0d want 4", count); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL t3_ready_full got %0b want 0", in_ready); end
        n_cmp++; if (out_we !== 1'b0) begin n_err++; $display("FAIL t3_we_stall got %0b want 0", out_we); end
        step();
        n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL t3_held got %0d want 4", count); end
        wb_stall = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL t4_ready_draining got %0b want 0", in_ready); end
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (count !== exp_cnt[i]) begin n_err++; $display("FAIL t34_count[%0d] got %0d want %0d", i, count, exp_cnt[i]); end
            n_cmp++; if ({out_we, out_wa, out_wd} !== {1'b1, exp_wa[i], exp_wd[i]})
                begin n_err++; $display("FAIL t34_write[%0d] got %0b/%0d/%0h want 1/%0d/%0h", i, out_we, out_wa, out_wd, exp_wa[i], exp_wd[i]); end
            step();
            if (i == 1) in_valid = 1'b0;
        end
        n_cmp++; if ({out_we, count} !== 4'd0) begin n_err++; $display("FAIL t34_drained got %0b/%0d want 0/0", out_we, count); end
    endtask

    task automatic test_forward();
        wb_stall = 1'b1; fwd_ra = 5'd7;
        push(5'd7, 64'd1);
        n_cmp++; if ({fwd_hit, fwd_data} !== (FWD ? {1'b1, 64'd1} : 65'd0)) begin n_err++; $display("FAIL t5_first got %0b/%0h", fwd_hit, fwd_data); end
        push(5'd7, 64'd2);
        push(5'd3, 64'd9);
        n_cmp++; if ({fwd_hit, fwd_data} !== (FWD ? {1'b1, 64'd2} : 65'd0)) begin n_err++; $display("FAIL t5_youngest got %0b/%0h", fwd_hit, fwd_data); end
        fwd_ra = 5'd0; #1;
        n_cmp++; if ({fwd_hit, fwd_data} !== 65'd0) begin n_err++; $display("FAIL t5_r0 got %0b/%0h want 0/0", fwd_hit, fwd_data); end
        fwd_ra = 5'd3; #1;
        n_cmp++; if ({fwd_hit, fwd_data} !== (FWD ? {1'b1, 64'd9} : 65'd0)) begin n_err++; $display("FAIL t5_r3 got %0b/%0h", fwd_hit, fwd_data); end
        fwd_ra = 5'd5; #1;
        n_cmp++; if ({fwd_hit, fwd_data} !== 65'd0) begin n_err++; $display("FAIL t5_miss got %0b/%0h want 0/0", fwd_hit, fwd_data); end
        fwd_ra = 5'd7; wb_stall = 1'b0; #1;
        n_cmp++; if ({out_we, out_wa, fwd_hit, fwd_data} !== {1'b1, 5'd7, (FWD ? {1'b1, 64'd2} : 65'd0)})
            begin n_err++; $display("FAIL t5_popping got %0b/%0d/%0b/%0h", out_we, out_wa, fwd_hit, fwd_data); end
        step();
        n_cmp++; if ({out_wd, fwd_hit} !== {64'd2, FWD}) begin n_err++; $display("FAIL t5_second got %0h/%0b", out_wd, fwd_hit); end
        step();
        n_cmp++; if ({out_wa, fwd_hit} !== {5'd3, 1'b0}) begin n_err++; $display("FAIL t5_gone got %0d/%0b want 3/0", out_wa, fwd_hit); end
        step();
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL t5_drained got %0d want 0", count); end
    endtask

    task automatic test_reset_mid();
        wb_stall = 1'b1;
        push(5'd10, 64'hA); push(5'd11, 64'hB); push(5'd12, 64'hC);
        n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL t6_count_pre got %0d want 3", count); end
        wb_stall = 1'b0; fwd_ra = 5'd11;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({out_we, count, in_ready, fwd_hit} !== 6'd0) begin n_err++; $display("FAIL t6_async got we=%0b cnt=%0d rdy=%0b hit=%0b want 0", out_we, count, in_ready, fwd_hit); end
        #2 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++; if ({out_we, count} !== 4'd0) begin n_err++; $display("FAIL t6_stale[%0d] got %0b/%0d want 0/0", i, out_we, count); end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_single_write();
        test_r0_drop();
        test_full_and_order();
        test_forward();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
